// File: rtl/mult_seq_controller.sv
// mult_seq_controller: sequences the shift-add multiplier datapath strobes from a start request to a done pulse.
module mult_seq_controller #(
  parameter int NBITS = 4,
  parameter bit SKIP_ZERO = 1'b1,
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mr0,
  input  logic          mr1,
  input  logic          mr2,
  input  logic          mr3,
  output logic          busy,
  output logic          done,
  output logic          mdld,
  output logic          mrld,
  output logic          rsclear,
  output logic          rsload,
  output logic          rsshr,
  output logic [IW-1:0] bit_idx
);
  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d, next_idx;
  logic [3:0] mr;
  logic last;
  assign mr = {mr3, mr2, mr1, mr0};
  assign next_idx = bit_idx_q + 1'b1;
  assign last = bit_idx_q == IW'(NBITS - 1);
  always_comb begin
    state_d = state_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE:  state_d = start ? LOAD : IDLE;
      LOAD: begin
        state_d = ADD;
        bit_idx_d = '0;
      end
      ADD:   state_d = SHIFT;
      SHIFT: begin
        bit_idx_d = last ? bit_idx_q : next_idx;
        state_d = last ? DONE : (SKIP_ZERO && !mr[next_idx]) ? SHIFT : ADD;
      end
      DONE: begin
        state_d = IDLE;
        bit_idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_idx_q <= '0;
    end else begin
      state_q <= state_d;
      bit_idx_q <= bit_idx_d;
    end
  end
  // Moore decode; only rsload looks at the live multiplier bit.
  assign busy    = state_q == LOAD || state_q == ADD || state_q == SHIFT;
  assign done    = state_q == DONE;
  assign mdld    = state_q == LOAD;
  assign mrld    = state_q == LOAD;
  assign rsclear = state_q == LOAD;
  assign rsload  = state_q == ADD && mr[bit_idx_q];
  assign rsshr   = state_q == SHIFT;
  assign bit_idx = bit_idx_q;
endmodule

// File: tb/tb_mult_seq_controller.sv
// tb_mult_seq_controller: drives a fixed-latency and a zero-skipping controller side by side, each with a behavioural datapath.
module tb_mult_seq_controller;
  logic clk, rst_n, start;
  logic [3:0] a_in, b_in;
  logic busy_w[2], done_w[2], mdld_w[2], mrld_w[2], rsclear_w[2], rsload_w[2], rsshr_w[2];
  logic [1:0] bit_idx_w[2];
  logic [3:0] md_r[2], mr_r[2];
  logic [8:0] sum_r[2];
  int checks, errors;
  int done_k[2], n_done[2], n_busy[2], n_add[2], n_shr[2];
  logic [3:0] ld_mask[2];
  logic [7:0] prod[2];
  logic prev_done[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    mult_seq_controller #(.NBITS(4), .SKIP_ZERO(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mr0(mr_r[g][0]), .mr1(mr_r[g][1]), .mr2(mr_r[g][2]), .mr3(mr_r[g][3]),
      .busy(busy_w[g]), .done(done_w[g]), .mdld(mdld_w[g]), .mrld(mrld_w[g]),
      .rsclear(rsclear_w[g]), .rsload(rsload_w[g]), .rsshr(rsshr_w[g]), .bit_idx(bit_idx_w[g])
    );
    // Datapath priority: shift over add over clear; add lands in the upper nibble.
    always @(posedge clk) begin
      if (mdld_w[g]) md_r[g] <= a_in;
      if (mrld_w[g]) mr_r[g] <= b_in;
      if (rsshr_w[g]) sum_r[g] <= sum_r[g] >> 1;
      else if (rsload_w[g]) sum_r[g] <= sum_r[g] + {1'b0, md_r[g], 4'b0};
      else if (rsclear_w[g]) sum_r[g] <= '0;
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      md_r[i] = '0;
      mr_r[i] = '0;
      sum_r[i] = '0;
      prev_done[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ((rsload_w[i] && rsshr_w[i]) || (rsclear_w[i] && !(mdld_w[i] && mrld_w[i] && busy_w[i]))
          || (done_w[i] && (busy_w[i] || prev_done[i]))) begin
        errors++;
        $display("FAIL cycle_rules dut%0d: rsload=%b rsshr=%b rsclear=%b mdld=%b busy=%b done=%b prev_done=%b required no overlap, clear only in load, single-cycle done without busy",
                 i, rsload_w[i], rsshr_w[i], rsclear_w[i], mdld_w[i], busy_w[i], done_w[i], prev_done[i]);
      end
      prev_done[i] = done_w[i];
    end
  end

  function automatic logic [8:0] outs(input int i);
    return {busy_w[i], done_w[i], mdld_w[i], mrld_w[i], rsclear_w[i], rsload_w[i], rsshr_w[i], bit_idx_w[i]};
  endfunction

  task automatic observe(input int k);
    for (int i = 0; i < 2; i++) begin
      if (done_w[i]) begin
        n_done[i]++;
        if (done_k[i] == 0) done_k[i] = k;
        prod[i] = sum_r[i][7:0];
      end
      if (busy_w[i]) n_busy[i]++;
      if (rsload_w[i]) ld_mask[i][bit_idx_w[i]] = 1'b1;
      if (busy_w[i] && !mdld_w[i] && !rsshr_w[i]) n_add[i]++;
      if (rsshr_w[i]) n_shr[i]++;
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit stray);
    a_in = a;
    b_in = b;
    for (int i = 0; i < 2; i++) begin
      done_k[i] = 0; n_done[i] = 0; n_busy[i] = 0; n_add[i] = 0; n_shr[i] = 0;
      ld_mask[i] = '0; prod[i] = '0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      observe(k);
      start = stray && (k == 3 || k == 8);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (outs(i) !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b required 0", i, outs(i));
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (outs(i) !== 9'd0) begin
        errors++;
        $display("FAIL idle_outputs dut%0d: got %b required 0", i, outs(i));
      end
    end
  endtask

  task automatic check_op(input logic [3:0] a, input logic [3:0] b);
    int z, exp_k, exp_add;
    z = 3 - $countones(b[3:1]);
    for (int i = 0; i < 2; i++) begin
      exp_k = (i == 0) ? 10 : 10 - z;
      exp_add = (i == 0) ? 4 : 4 - z;
      checks += 7;
      if (n_done[i] !== 1) begin errors++; $display("FAIL done_count dut%0d %0dx%0d: got %0d required 1", i, a, b, n_done[i]); end
      if (done_k[i] !== exp_k) begin errors++; $display("FAIL latency dut%0d %0dx%0d: got %0d required %0d", i, a, b, done_k[i], exp_k); end
      if (prod[i] !== 8'(a * b)) begin errors++; $display("FAIL product dut%0d %0dx%0d: got %0d required %0d", i, a, b, prod[i], a * b); end
      if (ld_mask[i] !== b) begin errors++; $display("FAIL rsload_bits dut%0d %0dx%0d: got %b required %b", i, a, b, ld_mask[i], b); end
      if (n_add[i] !== exp_add) begin errors++; $display("FAIL add_cycles dut%0d %0dx%0d: got %0d required %0d", i, a, b, n_add[i], exp_add); end
      if (n_shr[i] !== 4) begin errors++; $display("FAIL shift_cycles dut%0d %0dx%0d: got %0d required 4", i, a, b, n_shr[i]); end
      if (n_busy[i] !== exp_k - 1) begin errors++; $display("FAIL busy_cycles dut%0d %0dx%0d: got %0d required %0d", i, a, b, n_busy[i], exp_k - 1); end
    end
  endtask

  task automatic test_multiply();
    logic [3:0] da[6] = '{4'd13, 4'd15, 4'd9, 4'd15, 4'd6, 4'd0};
    logic [3:0] db[6] = '{4'd11, 4'd15, 4'd1, 4'd0, 4'd7, 4'd15};
    logic [3:0] a, b;
    for (int n = 0; n < 30; n++) begin
      a = (n < 6) ? da[n] : 4'($urandom_range(0, 15));
      b = (n < 6) ? db[n] : 4'($urandom_range(0, 15));
      run_op(a, b, 1'b0);
      check_op(a, b);
    end
  endtask

  task automatic test_ignored_start();
    run_op(4'd13, 4'd11, 1'b1);
    check_op(4'd13, 4'd11);
  endtask

  task automatic test_back_to_back();
    int first[2], second[2], cnt[2], k1;
    a_in = 4'd13;
    b_in = 4'd11;
    for (int i = 0; i < 2; i++) begin first[i] = 0; second[i] = 0; cnt[i] = 0; end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 25; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (done_w[i]) begin
          cnt[i]++;
          if (cnt[i] == 1) first[i] = k;
          if (cnt[i] == 2) second[i] = k;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      k1 = (i == 0) ? 10 : 9;
      checks += 3;
      if (first[i] !== k1) begin errors++; $display("FAIL b2b_first dut%0d: got %0d required %0d", i, first[i], k1); end
      if (second[i] !== 2 * k1 + 1) begin errors++; $display("FAIL b2b_second dut%0d: got %0d required %0d", i, second[i], 2 * k1 + 1); end
      if (cnt[i] !== 2) begin errors++; $display("FAIL b2b_count dut%0d: got %0d required 2", i, cnt[i]); end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    a_in = 4'd13;
    b_in = 4'd11;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (outs(i) !== 9'd0) begin errors++; $display("FAIL async_reset dut%0d: got %b required 0", i, outs(i)); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (outs(i) !== 9'd0) begin errors++; $display("FAIL held_reset dut%0d: got %b required 0", i, outs(i)); end
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (outs(i) !== 9'd0) begin errors++; $display("FAIL post_reset_idle dut%0d: got %b required 0", i, outs(i)); end
      end
    end
    run_op(4'd6, 4'd7, 1'b0);
    check_op(4'd6, 4'd7);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multiply();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
